// File: rtl/icache_fetch_arbiter.sv
// Two-thread Icache0 read-port arbiter with a single outstanding I-side miss channel.
// Define ICACHE_ARB_STATS_EN to add per-thread grant/miss counters (stat_grants, stat_misses).
module icache_fetch_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             smt_mode,
  input  logic             active_thread,
  input  logic [1:0]       thr_req,
  input  logic [1:0][63:0] thr_pc,
  input  logic [1:0]       thr_squash,
  input  logic [1:0]       Icache_hit,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [TAG_W-1:0] mem2proc_tag,
  input  logic [63:0]      mem2proc_data,
  output logic [1:0][63:0] proc2Icache_addr,
  output logic [1:0]       port_valid,
  output logic [1:0]       port_thread,
  output logic [1:0][63:0] port_pc,
  output logic [1:0]       thr_blocked,
  output logic [1:0]       proc2mem_command,
  output logic [63:0]      proc2mem_addr,
  output logic             fill_valid,
  output logic [63:0]      fill_addr,
  output logic [63:0]      fill_data
`ifdef ICACHE_ARB_STATS_EN
  ,
  output logic [1:0][31:0] stat_grants,
  output logic [1:0][31:0] stat_misses
`endif
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;

  state_t           state, state_nx;
  logic [1:0]       pending, blocked;
  logic [1:0]       pend_nx, blk_nx;
  logic [1:0][63:0] line_addr;
  logic             rr_ptr, owner;
  logic [TAG_W-1:0] mem_tag;
  logic [63:0]      txn_addr, txn_data;

  logic [1:0]       elig, miss, avail;
  logic [1:0][63:0] miss_addr;
  logic             grant_one, one_thr;
  logic             pick, pick_thr;

  assign thr_blocked = blocked;

  always_comb begin
    elig        = thr_req & ~blocked;
    port_valid  = '0;
    port_thread = '0;
    port_pc     = '0;
    grant_one   = 1'b0;
    one_thr     = active_thread;
    if (!reset) begin
      if (!smt_mode) begin
        grant_one = elig[active_thread];
      end else if (&elig) begin
        port_valid  = 2'b11;
        port_thread = 2'b10;
        port_pc     = thr_pc;
      end else if (|elig) begin
        grant_one = 1'b1;
        one_thr   = elig[1];
      end
    end
    if (grant_one) begin
      port_valid  = 2'b11;
      port_thread = {2{one_thr}};
      port_pc[0]  = thr_pc[one_thr];
      port_pc[1]  = thr_pc[one_thr] + 64'd4;
    end
    proc2Icache_addr[0] = {port_pc[0][63:3], 3'b000};
    proc2Icache_addr[1] = {port_pc[1][63:3], 3'b000};
  end

  // port 1 first so a port-0 miss of the same thread overrides it
  always_comb begin
    miss      = '0;
    miss_addr = '0;
    if (port_valid[1] && !Icache_hit[1]) begin
      miss[port_thread[1]]      = 1'b1;
      miss_addr[port_thread[1]] = proc2Icache_addr[1];
    end
    if (port_valid[0] && !Icache_hit[0]) begin
      miss[port_thread[0]]      = 1'b1;
      miss_addr[port_thread[0]] = proc2Icache_addr[0];
    end
    miss = miss & ~thr_squash;
  end

  always_comb begin
    avail            = (pending & ~thr_squash) | miss;
    state_nx         = state;
    pick             = 1'b0;
    pick_thr         = rr_ptr;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    fill_valid       = 1'b0;
    fill_addr        = '0;
    fill_data        = '0;
    unique case (state)
      IDLE: begin
        if (|avail) begin
          pick     = 1'b1;
          pick_thr = (&avail) ? rr_ptr : avail[1];
          state_nx = REQ;
        end
      end
      REQ: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = txn_addr;
        if (mem2proc_response != '0) state_nx = WAIT;
      end
      WAIT: begin
        if (mem_tag != '0 && mem2proc_tag == mem_tag) state_nx = FILL;
      end
      FILL: begin
        fill_valid = 1'b1;
        fill_addr  = txn_addr;
        fill_data  = txn_data;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // a newer miss from the owner (after a squash) keeps it blocked past the fill
  always_comb begin
    pend_nx = pending & ~thr_squash;
    blk_nx  = blocked & ~thr_squash;
    if (state == FILL && !pend_nx[owner]) blk_nx[owner] = 1'b0;
    pend_nx = pend_nx | miss;
    blk_nx  = blk_nx | miss;
    if (pick) pend_nx[pick_thr] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      blocked   <= '0;
      line_addr <= '0;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      mem_tag   <= '0;
      txn_addr  <= '0;
      txn_data  <= '0;
    end else begin
      state   <= state_nx;
      pending <= pend_nx;
      blocked <= blk_nx;
      if (miss[0]) line_addr[0] <= miss_addr[0];
      if (miss[1]) line_addr[1] <= miss_addr[1];
      if (pick) begin
        owner    <= pick_thr;
        rr_ptr   <= ~pick_thr;
        txn_addr <= pending[pick_thr] ? line_addr[pick_thr]
                                      : miss_addr[pick_thr];
      end
      if (state == REQ && mem2proc_response != '0) mem_tag <= mem2proc_response;
      if (state == WAIT && state_nx == FILL) txn_data <= mem2proc_data;
      if (state == FILL) mem_tag <= '0;
    end
  end

`ifdef ICACHE_ARB_STATS_EN
  logic [1:0][1:0] gcnt;

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [1:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_comb begin
    gcnt[0] = {1'b0, port_valid[0] && !port_thread[0]}
            + {1'b0, port_valid[1] && !port_thread[1]};
    gcnt[1] = {1'b0, port_valid[0] && port_thread[0]}
            + {1'b0, port_valid[1] && port_thread[1]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_grants <= '0;
      stat_misses <= '0;
    end else begin
      stat_grants[0] <= sat_add(stat_grants[0], gcnt[0]);
      stat_grants[1] <= sat_add(stat_grants[1], gcnt[1]);
      stat_misses[0] <= sat_add(stat_misses[0], {1'b0, miss[0]});
      stat_misses[1] <= sat_add(stat_misses[1], {1'b0, miss[1]});
    end
  end
`endif

endmodule
